// File: rtl/alu_pkg.sv
// Shared opcode encodings, controller state encoding and flag bit positions for alu_seq.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_W = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: bit 0 of B is consumed on the start edge, one more bit per cycle after.
// done is high for the single cycle in which product holds the complete result.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int Bus_Width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [Bus_Width-1:0]   A,
  input  logic [Bus_Width-1:0]   B,
  output logic                   busy,
  output logic                   done,
  output logic [2*Bus_Width-1:0] product
);

  localparam int Sh_Width = $clog2(Bus_Width);
  localparam logic [Sh_Width-1:0] LAST_STEP = Sh_Width'(Bus_Width - 1);

  logic [2*Bus_Width-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [Bus_Width-1:0]   mplier_q, mplier_d;
  logic [Sh_Width-1:0]    cnt_q, cnt_d;
  logic                   busy_q, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = B[0] ? {{Bus_Width{1'b0}}, A} : '0;
      mcand_d  = {{Bus_Width{1'b0}}, A} << 1;
      mplier_d = B >> 1;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == LAST_STEP) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == LAST_STEP);
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered valid/ready ALU with Z/C/V/N flags; ALU_SEQ_MUL_EN adds the multi-cycle multiply.
// state | meaning: ST_IDLE | accepting ops, ST_MUL | multiply in flight, input stalled
module alu_seq
  import alu_pkg::*;
#(
  parameter int Bus_Width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [Bus_Width-1:0] DataA,
  input  logic [Bus_Width-1:0] DataB,
  input  logic [2:0]           Inst_Sel,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [Bus_Width-1:0] Data_Out,
  output logic                 Zero,
  output logic                 Carry,
  output logic                 Overflow,
  output logic                 Negative
);

  localparam int Sh_Width = $clog2(Bus_Width);
  localparam logic [Bus_Width-1:0] SH_LIMIT = Bus_Width'(Bus_Width);

  logic                 valid_q, valid_d;
  logic [Bus_Width-1:0] data_q, data_d;
  logic [FLAG_W-1:0]    flags_q, flags_d;

  logic                 accept, load_res, shift_oob;
  logic [Bus_Width:0]   wide;
  logic [Bus_Width-1:0] alu_res, res_sel;
  logic                 alu_c, alu_v, c_sel, v_sel;

  assign accept    = In_Valid && In_Ready;
  assign shift_oob = (DataB >= SH_LIMIT);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    case (Inst_Sel)
      OP_AND: alu_res = DataA & DataB;
      OP_OR:  alu_res = DataA | DataB;
      OP_XOR: alu_res = DataA ^ DataB;
      OP_ADD: begin
        wide    = {1'b0, DataA} + {1'b0, DataB};
        alu_res = wide[Bus_Width-1:0];
        alu_c   = wide[Bus_Width];
        alu_v   = (DataA[Bus_Width-1] == DataB[Bus_Width-1]) &&
                  (alu_res[Bus_Width-1] != DataA[Bus_Width-1]);
      end
      OP_SUB: begin
        // top bit of the widened difference is the borrow
        wide    = {1'b0, DataA} - {1'b0, DataB};
        alu_res = wide[Bus_Width-1:0];
        alu_c   = wide[Bus_Width];
        alu_v   = (DataA[Bus_Width-1] != DataB[Bus_Width-1]) &&
                  (alu_res[Bus_Width-1] != DataA[Bus_Width-1]);
      end
      OP_SRL: alu_res = shift_oob ? '0 : (DataA >> DataB[Sh_Width-1:0]);
      OP_SLL: alu_res = shift_oob ? '0 : (DataA << DataB[Sh_Width-1:0]);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  alu_state_e             state_q, state_d;
  logic                   mul_start, mul_busy, mul_done, is_mul;
  logic [2*Bus_Width-1:0] mul_product;

  assign is_mul   = (Inst_Sel == OP_MUL);
  assign In_Ready = (state_q == ST_IDLE) && !mul_busy && (!valid_q || Out_Ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: if (accept && is_mul) begin
        mul_start = 1'b1;
        state_d   = ST_MUL;
      end
      ST_MUL:  if (mul_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  alu_mul_seq #(.Bus_Width(Bus_Width)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .A       (DataA),
    .B       (DataB),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign load_res = (accept && !is_mul) || ((state_q == ST_MUL) && mul_done);

  always_comb begin
    res_sel = alu_res;
    c_sel   = alu_c;
    v_sel   = alu_v;
    if (state_q == ST_MUL) begin
      res_sel = mul_product[Bus_Width-1:0];
      c_sel   = |mul_product[2*Bus_Width-1:Bus_Width];
      v_sel   = 1'b0;
    end
  end
`else
  assign In_Ready = !valid_q || Out_Ready;
  assign load_res = accept;
  assign res_sel  = alu_res;
  assign c_sel    = alu_c;
  assign v_sel    = alu_v;
`endif

  always_comb begin
    valid_d = valid_q && !Out_Ready;
    data_d  = data_q;
    flags_d = flags_q;
    if (load_res) begin
      valid_d         = 1'b1;
      data_d          = res_sel;
      flags_d[FLAG_Z] = (res_sel == '0);
      flags_d[FLAG_C] = c_sel;
      flags_d[FLAG_V] = v_sel;
      flags_d[FLAG_N] = res_sel[Bus_Width-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign Out_Valid = valid_q;
  assign Data_Out  = data_q;
  assign Zero      = flags_q[FLAG_Z];
  assign Carry     = flags_q[FLAG_C];
  assign Overflow  = flags_q[FLAG_V];
  assign Negative  = flags_q[FLAG_N];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table for single-cycle ops plus hand sequences
// for backpressure, reset-while-held and (with ALU_SEQ_MUL_EN) the multiply path.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         In_Valid = 1'b0;
  logic         Out_Ready = 1'b0;
  logic [W-1:0] DataA = '0;
  logic [W-1:0] DataB = '0;
  logic [2:0]   Inst_Sel = '0;
  logic         In_Ready, Out_Valid, Zero, Carry, Overflow, Negative;
  logic [W-1:0] Data_Out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.Bus_Width(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .DataA     (DataA),
    .DataB     (DataB),
    .Inst_Sel  (Inst_Sel),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Data_Out  (Data_Out),
    .Zero      (Zero),
    .Carry     (Carry),
    .Overflow  (Overflow),
    .Negative  (Negative)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   zcvn;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags_now();
    return {Zero, Carry, Overflow, Negative};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    In_Valid = 1'b1;
    Inst_Sel = op;
    DataA    = a;
    DataB    = b;
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic mul_case(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic c);
    int early;
    int stall_bad;
    early     = 0;
    stall_bad = 0;
    Out_Ready = 1'b1;
    drive(3'b011, a, b);
    #1 chk("mul_accept_ready", In_Ready, 1);
    tick();
    In_Valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (Out_Valid) early++;
      if (In_Ready) stall_bad++;
      tick();
    end
    chk("mul_no_early_valid", early, 0);
    chk("mul_in_ready_low", stall_bad, 0);
    chk("mul_valid_at_16", Out_Valid, 1);
    chk("mul_data", Data_Out, res);
    chk("mul_flags", flags_now(), {(res == '0), c, 1'b0, res[W-1]});
    tick();
    chk("mul_drained", Out_Valid, 0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int idx_in, idx_out, hold_bad, stale;
    logic [W-1:0] xa[3];
    logic [W-1:0] xb[3];
    logic [W-1:0] xr[3];
    logic in_fire, out_fire;

    //             op      A         B         result    ZCVN
    vecs[0]  = '{3'b010, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100};
    vecs[1]  = '{3'b110, 16'h8000, 16'h0001, 16'h7FFF, 4'b0010};
    vecs[2]  = '{3'b110, 16'h0001, 16'h0002, 16'hFFFF, 4'b0101};
    vecs[3]  = '{3'b101, 16'h0001, 16'h000F, 16'h8000, 4'b0001};
    vecs[4]  = '{3'b101, 16'h0001, 16'h0010, 16'h0000, 4'b1000};
    vecs[5]  = '{3'b100, 16'h8000, 16'h0004, 16'h0800, 4'b0000};
    vecs[6]  = '{3'b000, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000};
    vecs[7]  = '{3'b001, 16'hF0F0, 16'h0F00, 16'hFFF0, 4'b0001};
    vecs[8]  = '{3'b111, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000};
    vecs[9]  = '{3'b010, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011};
    vecs[10] = '{3'b100, 16'h8000, 16'hFFFF, 16'h0000, 4'b1000};
    vecs[11] = '{3'b110, 16'h0005, 16'h0005, 16'h0000, 4'b1000};

    // reset state
    #12;
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_data", Data_Out, 0);
    chk("rst_flags", flags_now(), 4'b0000);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", In_Ready, 1);

    // single-cycle ops, one per cycle
    Out_Ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      #1 chk($sformatf("v%0d_in_ready", i), In_Ready, 1);
      tick();
      chk($sformatf("v%0d_valid", i), Out_Valid, 1);
      chk($sformatf("v%0d_data", i), Data_Out, vecs[i].res);
      chk($sformatf("v%0d_flags", i), flags_now(), vecs[i].zcvn);
    end
    In_Valid = 1'b0;
    tick();
    chk("vec_drained", Out_Valid, 0);

    // backpressure with three back-to-back XORs
    xa = '{16'h1234, 16'h5555, 16'hFFFF};
    xb = '{16'h00FF, 16'h0F0F, 16'h8001};
    xr = '{16'h12CB, 16'h5A5A, 16'h7FFE};
    idx_in = 0; idx_out = 0; hold_bad = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      Out_Ready = (cyc >= 5);
      if (idx_in < 3) drive(3'b111, xa[idx_in], xb[idx_in]);
      else In_Valid = 1'b0;
      #1;
      if (cyc >= 1 && cyc <= 4) begin
        if (!Out_Valid || Data_Out !== xr[0] || In_Ready || flags_now() !== 4'b0000) hold_bad++;
      end
      in_fire  = In_Valid && In_Ready;
      out_fire = Out_Valid && Out_Ready;
      if (out_fire) begin
        if (idx_out < 3) chk($sformatf("bp_out%0d", idx_out), Data_Out, xr[idx_out]);
        idx_out++;
      end
      tick();
      if (in_fire) idx_in++;
    end
    chk("bp_hold_stable", hold_bad, 0);
    chk("bp_delivered", idx_out, 3);
    chk("bp_drained", Out_Valid, 0);

    // reset while a result is held clears output and flags
    Out_Ready = 1'b0;
    drive(3'b010, 16'hFFFF, 16'h0001);
    tick();
    In_Valid = 1'b0;
    tick();
    chk("held_valid", Out_Valid, 1);
    chk("held_flags", flags_now(), 4'b1100);
    reset = 1'b1;
    #1;
    chk("held_rst_valid", Out_Valid, 0);
    chk("held_rst_flags", flags_now(), 4'b0000);
    tick();
    reset = 1'b0;
    #1 chk("held_rst_in_ready", In_Ready, 1);
    Out_Ready = 1'b1;
    tick();
    chk("held_rst_no_output", Out_Valid, 0);

`ifdef ALU_SEQ_MUL_EN
    mul_case(16'h0100, 16'h0100, 16'h0000, 1'b1);
    mul_case(16'h00FF, 16'h0003, 16'h02FD, 1'b0);

    // reset in the middle of a multiply
    drive(3'b011, 16'h0100, 16'h0100);
    tick();
    In_Valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_mul_stalled", In_Ready, 0);
    reset = 1'b1;
    #1;
    chk("mid_mul_rst_valid", Out_Valid, 0);
    chk("mid_mul_rst_flags", flags_now(), 4'b0000);
    tick();
    tick();
    reset = 1'b0;
    #1 chk("mid_mul_in_ready", In_Ready, 1);
    stale = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (Out_Valid || !In_Ready) stale++;
    end
    chk("mid_mul_no_stale", stale, 0);
`else
    drive(3'b011, 16'h1234, 16'h0007);
    tick();
    In_Valid = 1'b0;
    chk("op011_valid", Out_Valid, 1);
    chk("op011_data", Data_Out, 16'h0000);
    chk("op011_flags", flags_now(), 4'b1000);
    tick();
    chk("op011_drained", Out_Valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
